regfile_wb: RTL and testbench
=============================

// Module: regfile_wb
// PURPOSE
//  Integer register file that feeds ALU operands (Reg1/Reg2) and accepts ALU_Result write-back.
//  Two combinational read ports and one handshaked write port.
//  x0 is hardwired to zero; same-cycle write-to-read bypass is built in.
//  A post-reset clear sequencer zeroes the array one entry per cycle, so the array needs no reset flops.
// PARAMETERS
//  XLEN   32  data width of each register and of the read/write data ports
//  NREGS  32  number of architectural registers, including x0
//  AW     5   address width; must satisfy 2**AW >= NREGS
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  rs1_addr   in   AW    read port 1 address
//  rs1_data   out  XLEN  read port 1 data (ALU Reg1)
//  rs2_addr   in   AW    read port 2 address
//  rs2_data   out  XLEN  read port 2 data (ALU Reg2)
//  wr_valid   in   1     write request
//  wr_ready   out  1     write port able to accept
//  wr_addr    in   AW    write address
//  wr_data    in   XLEN  write data (ALU_Result)
//  init_busy  out  1     clear sequence in progress
// BEHAVIOUR
//  Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
//  State machine: states INIT and READY. Clear counter clr_idx is AW bits.
//  Reset (rst_n=0, asynchronous):
//   - state=INIT, clr_idx=1, init_busy=1, wr_ready=0.
//   - rs1_data and rs2_data read 0.
//   - Array contents are don't-care.
//  INIT:
//   - Each cycle: array[clr_idx] <= 0, then clr_idx += 1.
//   - When clr_idx == NREGS-1, that entry is cleared and the next state is READY.
//   - INIT lasts NREGS-1 cycles after rst_n deasserts (31 at default).
//   - Writes are not accepted (wr_ready=0). Both read ports return 0.
//  READY:
//   - wr_ready=1, init_busy=0. No exit except by reset.
//  Write acceptance: wr_valid && wr_ready.
//   - array[wr_addr] <= wr_data on that edge.
//   - Writes with wr_addr==0 are accepted and discarded.
//   - Writes with wr_addr >= NREGS are accepted and discarded.
//  Reads: combinational, zero latency. rsN_data is evaluated in priority order:
//   1. 0 if state==INIT, rsN_addr==0, or rsN_addr >= NREGS;
//   2. else wr_data if a write is accepted this cycle with wr_addr==rsN_addr (bypass);
//   3. else array[rsN_addr].
//  Simultaneous events:
//   - Both read ports may hit the same address, including the bypassed one; each resolves independently.
//   - wr_valid held during INIT stalls. The first accept happens on the first READY cycle.
//  Reset mid-operation: an asserted rst_n immediately forces INIT and clr_idx=1.
//   - Any in-flight write is dropped.
//   - A full clear sequence reruns; no stale data is visible after re-entry to READY.
//  Width rules: data is stored and returned unmodified (no sign or zero extension). clr_idx wraps never.
// TESTING
//  T1 reset/clear: release rst_n.
//     -> init_busy=1 and wr_ready=0 for exactly 31 cycles.
//     -> Then a read of all 32 registers returns 0x00000000.
//  T2 write/read: write x5=0xDEADBEEF.
//     -> Next cycle rs1_addr=5 gives 0xDEADBEEF.
//     -> rs2_addr=6 gives 0x00000000.
//  T3 x0 immunity: write x0=0xFFFFFFFF.
//     -> rs1_addr=0 and rs2_addr=0 both return 0 on the same cycle and afterwards.
//  T4 bypass: rs1_addr=rs2_addr=7 while writing x7=0x12345678 in the same cycle.
//     -> Both read ports show 0x12345678 combinationally.
//     -> The value persists next cycle.
//  T5 INIT stall: hold wr_valid=1 with x3=0xA5A5A5A5 from reset release.
//     -> No accept until cycle 32.
//     -> x3 reads 0xA5A5A5A5 after the accept.
//  T6 reset mid-op: write x9=0x55, pulse rst_n low for 1 cycle.
//     -> 31-cycle INIT reruns.
//     -> x9 reads 0x00000000 afterwards.

Source files
------------

// File: rtl/regfile_wb.sv
// Integer register file: two zero-latency read ports, one valid/ready write port, x0 tied to zero.
// After reset a sequencer zeroes entries 1..NREGS-1 one per cycle; writes stall until it finishes.
module regfile_wb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            init_busy
);

    typedef enum logic {INIT, READY} state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);

    state_e          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            wr_ready_q;
    logic            init_busy_q;
    logic [XLEN-1:0] mem [NREGS];

    logic wr_fire;
    logic wr_keep;
    logic rs1_ok;
    logic rs2_ok;

    assign wr_ready  = wr_ready_q;
    assign init_busy = init_busy_q;
    assign wr_fire   = wr_valid && wr_ready_q;
    // Accepted writes to x0 or beyond the array are consumed but never stored.
    assign wr_keep   = wr_fire && (wr_addr != '0) && ({1'b0, wr_addr} < NREGS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            clr_idx_q   <= AW'(1);
            wr_ready_q  <= 1'b0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q     <= READY;
                        wr_ready_q  <= 1'b1;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                READY: begin
                    state_q     <= READY;
                    wr_ready_q  <= 1'b1;
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= INIT;
                    clr_idx_q   <= AW'(1);
                    wr_ready_q  <= 1'b0;
                    init_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage carries no reset; the clear sequencer guarantees zeros before READY.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_keep) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rs1_ok = (state_q == READY) && (rs1_addr != '0) && ({1'b0, rs1_addr} < NREGS_W);
    assign rs2_ok = (state_q == READY) && (rs2_addr != '0) && ({1'b0, rs2_addr} < NREGS_W);

    always_comb begin
        rs1_data = '0;
        if (rs1_ok) begin
            if (wr_fire && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = mem[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_ok) begin
            if (wr_fire && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = mem[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios plus random traffic against an array-based model.
module tb_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_busy;

    int total;
    int bad;

    logic [31:0] ref_mem [32];
    int          init_cycles;

    regfile_wb #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .rs2_addr  (rs2_addr),
        .rs2_data  (rs2_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference read: x0 is zero, a same-cycle write to the address wins, else stored value.
    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic wv,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wv && (wa == a)) return wd;
        return ref_mem[a];
    endfunction

    // One READY-state cycle: drive at negedge, check reads, clock, update model.
    task automatic step(input string tag, input logic wv, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        #1;
        check({tag, ".rs1"}, rs1_data, model_rd(a1, wv, wa, wd));
        check({tag, ".rs2"}, rs2_data, model_rd(a2, wv, wa, wd));
        @(posedge clk);
        if (wv && wa != 5'd0) ref_mem[wa] = wd;
        @(negedge clk);
    endtask

    // Counts cycles with init_busy high from reset release; checks port behaviour meanwhile.
    task automatic run_init(input string tag);
        init_cycles = 0;
        while (init_busy === 1'b1 && init_cycles < 100) begin
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            #1;
            check({tag, ".init_wr_ready"}, {31'd0, wr_ready}, 32'd0);
            check({tag, ".init_rs1"}, rs1_data, 32'd0);
            check({tag, ".init_rs2"}, rs2_data, 32'd0);
            @(posedge clk);
            @(negedge clk);
            init_cycles++;
        end
        check({tag, ".init_len"}, 32'(init_cycles), 32'd31);
        check({tag, ".ready_after"}, {31'd0, wr_ready}, 32'd1);
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.init_busy", {31'd0, init_busy}, 32'd1);
        check("rst.wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst.rs1", rs1_data, 32'd0);
        check("rst.rs2", rs2_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rs1_addr = 5'd5; rs2_addr = 5'd9;

        // T1: reset, clear sequence, all registers zero
        apply_reset();
        run_init("t1");
        for (int i = 0; i < 32; i++) step("t1.zero", 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));

        // T2: write then read back
        step("t2.wr", 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
        check("t2.x5", rs1_data, 32'hDEADBEEF);
        check("t2.x6", rs2_data, 32'h0);
        @(negedge clk);

        // T3: x0 ignores writes, including the same cycle
        step("t3.wr", 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
        check("t3.x0a", rs1_data, 32'h0);
        check("t3.x0b", rs2_data, 32'h0);
        @(negedge clk);

        // T4: bypass to both ports, then persistence
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
        check("t4.byp1", rs1_data, 32'h12345678);
        check("t4.byp2", rs2_data, 32'h12345678);
        @(posedge clk); ref_mem[7] = 32'h12345678; @(negedge clk);
        wr_valid = 1'b0; #1;
        check("t4.keep1", rs1_data, 32'h12345678);
        check("t4.keep2", rs2_data, 32'h12345678);
        @(negedge clk);

        // Random traffic, biased so reads often collide with the write address
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  wa, a1, a2;
            logic        wv;
            wv = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step("rnd", wv, wa, $urandom, a1, a2);
        end

        // T6: reset mid-operation drops the in-flight write and reclears
        step("t6.wr", 1'b1, 5'd9, 32'h55, 5'd9, 5'd3);
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
        rs1_addr = 5'd9;
        apply_reset();
        wr_valid = 1'b0;
        run_init("t6");
        rs1_addr = 5'd9; rs2_addr = 5'd7; #1;
        check("t6.x9", rs1_data, 32'h0);
        check("t6.x7", rs2_data, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 32; i++) step("t6.zero", 1'b0, 5'd0, 32'd0, 5'(i), 5'(i ^ 1));

        // T5: write held through INIT is accepted on the first READY cycle
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        apply_reset();
        run_init("t5");
        rs1_addr = 5'd3; rs2_addr = 5'd4; #1;
        check("t5.accept_rdy", {31'd0, wr_ready && wr_valid}, 32'd1);
        check("t5.byp", rs1_data, 32'hA5A5A5A5);
        @(posedge clk); ref_mem[3] = 32'hA5A5A5A5; @(negedge clk);
        wr_valid = 1'b0; #1;
        check("t5.x3", rs1_data, 32'hA5A5A5A5);
        check("t5.x4", rs2_data, 32'h0);
        @(negedge clk);
        step("t5.after", 1'b0, 5'd0, 32'd0, 5'd3, 5'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
